// File: rtl/golden_nonce_uart_reporter.sv
// Golden-nonce FIFO plus 8N1 UART serialiser (MSB byte first, 4 bytes per nonce), hash_clk only.
// Define GOLDEN_NONCE_DEDUP_EN to discard a nonce equal to the most recently pushed one.
module golden_nonce_uart_reporter #(
    parameter int unsigned FIFO_DEPTH_LOG2 = 3,
    parameter int unsigned CLKS_PER_BIT    = 868
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       nonce_valid,
    input  logic [31:0]                nonce_in,
    output logic                       uart_tx,
    output logic [FIFO_DEPTH_LOG2:0]   fifo_count,
    output logic                       overflow,
    output logic                       busy
);

    localparam int unsigned Depth = 1 << FIFO_DEPTH_LOG2;
    localparam int unsigned CntW  = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e                     state_q, state_d;
    logic [31:0]                mem [Depth];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_DEPTH_LOG2:0]   count_q, count_d;
    logic                       overflow_q;
    logic [31:0]                frame_q;
    logic [CntW-1:0]            cnt_q;
    logic [2:0]                 bit_idx_q;
    logic [1:0]                 byte_idx_q;
    logic                       tx_q, tx_d;
    logic [7:0]                 cur_byte;
    logic                       full, dup, push, drop, pop, bit_done;

`ifdef GOLDEN_NONCE_DEDUP_EN
    logic [31:0] last_q;
    logic        last_vld_q;

    assign dup = last_vld_q && (nonce_in == last_q);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_q     <= '0;
            last_vld_q <= 1'b0;
        end else if (push) begin
            last_q     <= nonce_in;
            last_vld_q <= 1'b1;
        end
    end
`else
    assign dup = 1'b0;
`endif

    // count never exceeds Depth, so its MSB alone flags full
    assign full     = count_q[FIFO_DEPTH_LOG2];
    assign push     = nonce_valid && !dup && !full;
    assign drop     = nonce_valid && !dup && full;
    assign bit_done = (cnt_q == CntMax);

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= nonce_in;
        end
    end

    // State register and datapath
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            frame_q    <= '0;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tx_q    <= tx_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                frame_q  <= mem[rd_ptr_q];
            end
            if (state_q == StIdle || state_d != state_q || bit_done) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q != StData) begin
                bit_idx_q <= '0;
            end else if (bit_done) begin
                bit_idx_q <= bit_idx_q + 1'b1;
            end
            if (pop) begin
                byte_idx_q <= '0;
            end else if (state_q == StStop && bit_done && byte_idx_q != 2'd3) begin
                byte_idx_q <= byte_idx_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (count_q != '0) state_d = StStart;
            StStart: if (bit_done) state_d = StData;
            StData:  if (bit_done && bit_idx_q == 3'd7) state_d = StStop;
            StStop:  if (bit_done) state_d = (byte_idx_q != 2'd3) ? StStart : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // tx_d depends only on current state, so the line lags the FSM by one cycle
    always_comb begin
        pop      = 1'b0;
        busy     = 1'b1;
        tx_d     = 1'b1;
        cur_byte = frame_q[31:24];
        unique case (byte_idx_q)
            2'd0:    cur_byte = frame_q[31:24];
            2'd1:    cur_byte = frame_q[23:16];
            2'd2:    cur_byte = frame_q[15:8];
            default: cur_byte = frame_q[7:0];
        endcase
        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
                pop  = (count_q != '0);
            end
            StStart: tx_d = 1'b0;
            StData:  tx_d = cur_byte[bit_idx_q];
            default: tx_d = 1'b1;
        endcase
    end

    assign uart_tx    = tx_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_golden_nonce_uart_reporter.sv
// Bench for golden_nonce_uart_reporter: UART monitor decodes frames and checks them against
// a scoreboard of expected nonces; scenario tasks check timing, FIFO and overflow behaviour.
module tb_golden_nonce_uart_reporter;

    localparam int unsigned L     = 2;
    localparam int unsigned C     = 4;
    localparam int          Half  = C / 2;
    localparam int          Frame = 40 * C;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         nonce_valid = 1'b0;
    logic [31:0]  nonce_in = '0;
    logic         uart_tx;
    logic [L:0]   fifo_count;
    logic         overflow;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] exp_q[$];
    int          frame_start_q[$];
    int          rx_frames = 0;

    golden_nonce_uart_reporter #(
        .FIFO_DEPTH_LOG2(L),
        .CLKS_PER_BIT   (C)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .nonce_valid(nonce_valid),
        .nonce_in   (nonce_in),
        .uart_tx    (uart_tx),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // UART receiver: tick 0 is the first low cycle of a start bit
    bit          rx_active = 1'b0;
    int          rx_tick = 0;
    int          rx_bidx = 0;
    int          last_byte_start = 0;
    logic [7:0]  rx_byte = '0;
    logic [31:0] rx_word = '0;
    logic [31:0] rx_exp;

    always @(negedge clk) begin
        if (reset_n !== 1'b1) begin
            rx_active = 1'b0;
            rx_bidx   = 0;
        end else if (!rx_active) begin
            if (uart_tx === 1'b0) begin
                rx_active = 1'b1;
                rx_tick   = 0;
                if (rx_bidx == 0) begin
                    frame_start_q.push_back(cyc);
                end else begin
                    checks++;
                    if (cyc != last_byte_start + 10 * C) begin
                        errors++;
                        $display("FAIL byte_gap: start at %0d, required %0d", cyc,
                                 last_byte_start + 10 * C);
                    end
                end
                last_byte_start = cyc;
            end
        end else begin
            rx_tick++;
            if (rx_tick == Half) begin
                checks++;
                if (uart_tx !== 1'b0) begin
                    errors++;
                    $display("FAIL start_bit: got %b, required 0", uart_tx);
                end
            end else if (rx_tick > Half && (rx_tick - Half) % C == 0) begin
                if ((rx_tick - Half) / C <= 8) begin
                    rx_byte[(rx_tick - Half) / C - 1] = uart_tx;
                end else begin
                    checks++;
                    if (uart_tx !== 1'b1) begin
                        errors++;
                        $display("FAIL stop_bit: got %b, required 1", uart_tx);
                    end
                    rx_word   = {rx_word[23:0], rx_byte};
                    rx_active = 1'b0;
                    rx_bidx++;
                    if (rx_bidx == 4) begin
                        rx_bidx = 0;
                        rx_frames++;
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_frame: got %h, none expected", rx_word);
                        end else begin
                            rx_exp = exp_q.pop_front();
                            if (rx_word !== rx_exp) begin
                                errors++;
                                $display("FAIL frame_data: got %h, required %h", rx_word, rx_exp);
                            end
                        end
                    end
                end
            end
        end
    end

    // Waits for scoreboard empty and DUT idle with an empty FIFO
    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && busy === 1'b0 && fifo_count === '0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (uart_tx !== 1'b1 || busy !== 1'b0 || fifo_count !== '0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: tx=%b busy=%b count=%0d ovf=%b, required 1 0 0 0",
                     uart_tx, busy, fifo_count, overflow);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        int busy_cycles;
        bit ok;
        exp_q.push_back(32'h01D00A5C);
        @(negedge clk);
        nonce_valid = 1'b1;
        nonce_in    = 32'h01D00A5C;
        @(negedge clk);
        nonce_valid = 1'b0;
        checks++;
        if (fifo_count !== 3'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL latency_push: count=%0d busy=%b, required 1 0", fifo_count, busy);
        end
        @(negedge clk);
        checks++;
        if (fifo_count !== 3'd0 || busy !== 1'b1 || uart_tx !== 1'b1) begin
            errors++;
            $display("FAIL latency_pop: count=%0d busy=%b tx=%b, required 0 1 1",
                     fifo_count, busy, uart_tx);
        end
        busy_cycles = 1;
        @(negedge clk);
        checks++;
        if (uart_tx !== 1'b0) begin
            errors++;
            $display("FAIL latency_tx: tx=%b, required 0", uart_tx);
        end
        for (int i = 0; i < 400 && busy === 1'b1; i++) begin
            busy_cycles++;
            @(negedge clk);
        end
        checks++;
        if (busy_cycles != Frame) begin
            errors++;
            $display("FAIL busy_length: got %0d, required %0d", busy_cycles, Frame);
        end
        wait_drain(200, ok);
        checks++;
        if (!ok || rx_frames != 1) begin
            errors++;
            $display("FAIL single_frame: frames=%0d drained=%0b, required 1 1", rx_frames, ok);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [3];
        int          peak;
        int          base;
        bit          ok;
        vals[0] = 32'h11111111;
        vals[1] = 32'h22222222;
        vals[2] = 32'h33333333;
        base    = frame_start_q.size();
        peak    = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
            nonce_valid = 1'b1;
            nonce_in    = vals[i];
            exp_q.push_back(vals[i]);
        end
        @(negedge clk);
        nonce_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
            @(negedge clk);
        end
        checks++;
        if (peak != 2) begin
            errors++;
            $display("FAIL peak_count: got %0d, required 2", peak);
        end
        wait_drain(800, ok);
        checks++;
        if (!ok || frame_start_q.size() != base + 3) begin
            errors++;
            $display("FAIL b2b_frames: frames=%0d drained=%0b, required 3 1",
                     frame_start_q.size() - base, ok);
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (frame_start_q[base + i] - frame_start_q[base + i - 1] != Frame + 1) begin
                    errors++;
                    $display("FAIL b2b_gap: got %0d, required %0d",
                             frame_start_q[base + i] - frame_start_q[base + i - 1], Frame + 1);
                end
            end
        end
    endtask

    task automatic test_overflow();
        bit ok;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            nonce_valid = 1'b1;
            nonce_in    = 32'(i);
            if (i <= 5) exp_q.push_back(32'(i));
        end
        @(negedge clk);
        nonce_valid = 1'b0;
        checks++;
        if (overflow !== 1'b1 || fifo_count !== 3'd4) begin
            errors++;
            $display("FAIL overflow_set: ovf=%b count=%0d, required 1 4", overflow, fifo_count);
        end
        wait_drain(1200, ok);
        checks++;
        if (!ok || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky: ovf=%b drained=%0b, required 1 1", overflow, ok);
        end
    endtask

    task automatic test_mid_frame_reset();
        int frames0;
        int low_cycles;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            nonce_valid = 1'b1;
            nonce_in    = 32'hC0DE0000 + 32'(i);
        end
        @(negedge clk);
        nonce_valid = 1'b0;
        for (int i = 0; i < 20 && busy !== 1'b1; i++) @(negedge clk);
        repeat (69) @(negedge clk);
        checks++;
        if (fifo_count !== 3'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: count=%0d busy=%b, required 2 1", fifo_count, busy);
        end
        frames0 = rx_frames;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        checks++;
        if (uart_tx !== 1'b1 || busy !== 1'b0 || fifo_count !== '0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: tx=%b busy=%b count=%0d ovf=%b, required 1 0 0 0",
                     uart_tx, busy, fifo_count, overflow);
        end
        low_cycles = 0;
        repeat (300) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || busy !== 1'b0) low_cycles++;
        end
        checks++;
        if (low_cycles != 0 || rx_frames != frames0) begin
            errors++;
            $display("FAIL post_reset_quiet: active=%0d frames=%0d, required 0 %0d",
                     low_cycles, rx_frames, frames0);
        end
    endtask

    task automatic test_push_pop_full();
        bit ok;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            nonce_valid = 1'b1;
            nonce_in    = 32'hF0000000 + 32'(i);
            exp_q.push_back(32'hF0000000 + 32'(i));
        end
        @(negedge clk);
        nonce_valid = 1'b0;
        checks++;
        if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL fill: count=%0d ovf=%b, required 4 0", fifo_count, overflow);
        end
        for (int i = 0; i < 400 && busy !== 1'b0; i++) @(negedge clk);
        nonce_valid = 1'b1;
        nonce_in    = 32'hDEADBEEF;
        @(negedge clk);
        nonce_valid = 1'b0;
        checks++;
        if (fifo_count !== 3'd3 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL push_pop_full: count=%0d ovf=%b, required 3 1", fifo_count, overflow);
        end
        wait_drain(1000, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL push_pop_drain: pending=%0d, required 0", exp_q.size());
        end
    endtask

    task automatic test_dedup();
        logic [31:0] vals [4];
        int          frames0;
        int          want;
        bit          ok;
        vals[0] = 32'hAAAA0000;
        vals[1] = 32'hAAAA0000;
        vals[2] = 32'hBBBB0000;
        vals[3] = 32'hAAAA0000;
        frames0 = rx_frames;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            nonce_valid = 1'b1;
            nonce_in    = vals[i];
`ifdef GOLDEN_NONCE_DEDUP_EN
            if (i != 1) exp_q.push_back(vals[i]);
`else
            exp_q.push_back(vals[i]);
`endif
        end
        @(negedge clk);
        nonce_valid = 1'b0;
`ifdef GOLDEN_NONCE_DEDUP_EN
        want = 3;
`else
        want = 4;
`endif
        wait_drain(1000, ok);
        checks++;
        if (!ok || rx_frames - frames0 != want || overflow !== 1'b1) begin
            errors++;
            $display("FAIL dedup_frames: got %0d drained=%0b ovf=%b, required %0d 1 1",
                     rx_frames - frames0, ok, overflow, want);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_mid_frame_reset();
        test_push_pop_full();
        test_dedup();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected: got %0d, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
